// File: rtl/disp_rd_buf.sv
// ============================================================================
// disp_rd_buf : display read buffer. Prefetches SDRAM pixel bursts into a
// FIFO and pops one pixel per display request. Optional macro DISP_UFLOW_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module disp_rd_buf #(
    parameter int DEPTH        = 1024,
    parameter int BURST_LEN    = 256,
    parameter int ADDR_W       = 22,
    parameter int FRAME_BASE   = 0,
    parameter int FRAME_PIXELS = 384000
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              pix_req,
    input  logic              vga_vsync,
    output logic [23:0]       img_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [23:0]       rd_data,
    input  logic              rd_data_vld,
    output logic              uflow
`ifdef DISP_UFLOW_CNT_EN
    ,
    output logic [15:0]       uflow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);

    localparam logic [CW-1:0]     c_depth     = CW'(DEPTH);
    localparam logic [CW-1:0]     c_req_thr   = CW'(DEPTH - BURST_LEN);
    localparam logic [BW-1:0]     c_last_beat = BW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] c_end       = ADDR_W'(FRAME_BASE + FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] c_burst     = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RECV  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t            state_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [BW-1:0]     beat_q;
    logic              vsync_q;
    logic              pend_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [23:0]       img_q;
    logic              uflow_q;
    logic [23:0]       mem [DEPTH];

    logic              w_vs_rise;
    logic              w_flush_req;
    logic              w_do_wr;
    logic              w_do_pop;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_addr_next;
    logic [23:0]       w_head;

    // A vsync edge in the same cycle as the decision counts as pending already.
    assign w_vs_rise   = vga_vsync & ~vsync_q;
    assign w_flush_req = pend_q | w_vs_rise;
    assign w_do_wr     = rd_data_vld & (count_q != c_depth);
    assign w_do_pop    = pix_req & (count_q != '0);
    assign count_d     = count_q + CW'(w_do_wr) - CW'(w_do_pop);
    assign w_addr_inc  = rd_addr_q + c_burst;
    assign w_addr_next = (w_addr_inc == c_end) ? c_base : w_addr_inc;
    assign w_head      = mem[rd_ptr_q];

    always_ff @(posedge sclk) begin
        if (w_do_wr) begin
            mem[wr_ptr_q] <= rd_data;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            rd_req_q  <= 1'b0;
            rd_addr_q <= c_base;
            beat_q    <= '0;
            vsync_q   <= 1'b0;
            pend_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            img_q     <= 24'h000000;
            uflow_q   <= 1'b0;
        end else begin
            vsync_q <= vga_vsync;
            if (w_vs_rise) begin
                pend_q <= 1'b1;
            end
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;

            if (pix_req) begin
                if (w_do_pop) begin
                    img_q <= w_head;
                end else begin
                    img_q   <= 24'h000000;
                    uflow_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_flush_req) begin
                        state_q <= ST_FLUSH;
                    end else if (count_q <= c_req_thr) begin
                        state_q  <= ST_REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        rd_req_q <= 1'b0;
                        beat_q   <= '0;
                        state_q  <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    // A burst is never aborted; a pending flush waits for its last beat.
                    if (rd_data_vld) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == c_last_beat) begin
                            rd_addr_q <= w_addr_next;
                            state_q   <= w_flush_req ? ST_FLUSH : ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    wr_ptr_q  <= '0;
                    rd_ptr_q  <= '0;
                    count_q   <= '0;
                    rd_addr_q <= c_base;
                    uflow_q   <= 1'b0;
                    pend_q    <= w_vs_rise;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DISP_UFLOW_CNT_EN
    logic [15:0] uflow_cnt_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            uflow_cnt_q <= 16'h0000;
        end else if (pix_req && !w_do_pop && (uflow_cnt_q != 16'hFFFF)) begin
            uflow_cnt_q <= uflow_cnt_q + 16'h0001;
        end
    end

    assign uflow_cnt = uflow_cnt_q;
`endif

    assign img_data = img_q;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign uflow    = uflow_q;

endmodule

`default_nettype wire
